// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and default payload width.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LAUNCH   = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_WAIT_END = 2'd3
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set request at or above ptr, wrapping around.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [PTR_W-1:0]   winner_idx,
    output logic               valid
);

    int idx;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        valid      = 1'b0;
        idx        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!valid && req[idx]) begin
                valid       = 1'b1;
                winner[idx] = 1'b1;
                winner_idx  = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// Optional WAIT_ACK timeout with tx_err pulse is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int NUM_REQ    = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          tx_start,
    output logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_busy,
    output logic                          arb_idle,
    output logic                          tx_err
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("uart_tx_arbiter: TIMEOUT must be at least 1");
    end

    state_t                 state, state_nxt;
    logic [PW-1:0]          rr_ptr;
    logic [NUM_REQ-1:0]     pick_oh;
    logic [PW-1:0]          pick_idx;
    logic                   pick_vld;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic                   launch;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PW)
    ) u_rr_pick (
        .req        (req),
        .ptr        (rr_ptr),
        .winner     (pick_oh),
        .winner_idx (pick_idx),
        .valid      (pick_vld)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_oh[i]) sel_data = sel_data | req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
`endif

    always_comb begin
        state_nxt = state;
`ifdef UART_ARB_TIMEOUT_EN
        tmo_hit   = 1'b0;
`endif
        case (state)
            ST_IDLE:     if (pick_vld && !tx_busy) state_nxt = ST_LAUNCH;
            ST_LAUNCH:   state_nxt = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (tx_busy) begin
                    state_nxt = ST_WAIT_END;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                    state_nxt = ST_IDLE;
                    tmo_hit   = 1'b1;
                end
`endif
            end
            ST_WAIT_END: if (!tx_busy) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    assign launch = (state == ST_IDLE) && (state_nxt == ST_LAUNCH);

    // Outputs are registered from the next-state decision so they line up with the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            grant    <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            arb_idle <= 1'b1;
        end else begin
            state    <= state_nxt;
            grant    <= launch ? pick_oh : '0;
            tx_start <= launch;
            arb_idle <= (state_nxt == ST_IDLE);
            if (launch) begin
                tx_data <= sel_data;
                rr_ptr  <= (pick_idx == PW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    // Counts consecutive WAIT_ACK cycles without tx_busy; cleared everywhere else.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            tx_err  <= 1'b0;
        end else begin
            tmo_cnt <= (state == ST_WAIT_ACK && state_nxt == ST_WAIT_ACK) ? tmo_cnt + 1'b1 : '0;
            tx_err  <= tmo_hit;
        end
    end
`else
    assign tx_err = 1'b0;
`endif

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, the frame payload width in bits.
REQ-002 The block SHALL have parameter NUM_REQ, default 4, the number of requesters (2..8).
REQ-003 The block SHALL have parameter TIMEOUT, default 64, the max cycles waited for tx_busy after tx_start.
REQ-004 Port clk  input  1  the single clock; all logic on rising edge.
REQ-005 Port rst_n  input  1  reset, synchronous and active-low.
REQ-006 Port req  input  NUM_REQ  level request per requester.
REQ-007 Port req_data  input  NUM_REQ*DATA_WIDTH  payloads; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 Port grant  output  NUM_REQ  one-hot, one-cycle pulse: requester's data accepted.
REQ-009 Port tx_start  output  1  one-cycle start pulse to the shared transmitter.
REQ-010 Port tx_data  output  DATA_WIDTH  registered payload to the transmitter, stable from tx_start until return to IDLE.
REQ-011 Port tx_busy  input  1  transmitter busy, high for the whole frame.
REQ-012 Port arb_idle  output  1  high while in IDLE.
REQ-013 Port tx_err  output  1  one-cycle pulse on transmitter timeout.

Function
REQ-014 The FSM SHALL have states IDLE, LAUNCH, WAIT_ACK, WAIT_END.
REQ-015 IDLE with any req bit high SHALL select the winner, latch its req_data into tx_data, and go to LAUNCH; no req -> stay IDLE.
REQ-016 Winner SHALL be the first set req bit searching upward (wrapping) from rr_ptr; rr_ptr SHALL become winner+1 modulo NUM_REQ on grant.
REQ-017 In LAUNCH (exactly one cycle) grant[winner] and tx_start SHALL be 1; next state WAIT_ACK; latency req-to-tx_start = 2 cycles from IDLE.
REQ-018 WAIT_ACK SHALL go to WAIT_END on tx_busy=1; otherwise count cycles, per REQ-027.
REQ-019 WAIT_END SHALL go to IDLE on tx_busy=0; no timeout in WAIT_END.
REQ-020 req changes outside IDLE SHALL be ignored; a req held high after grant is a new request, served again in round-robin order.
REQ-021 A requester SHALL not be granted twice consecutively while another req bit is high in IDLE.
REQ-022 All simultaneous requests SHALL resolve to exactly one grant; grant SHALL never have more than one bit set.
REQ-023 tx_busy high while in IDLE SHALL block arbitration (stay IDLE) until it falls.
REQ-024 Outputs SHALL be registered; no combinational path from req or tx_busy to any output.

Reset
REQ-025 rst_n=0 at a clock edge SHALL force state IDLE, rr_ptr=0, grant=0, tx_start=0, tx_data=0, tx_err=0, arb_idle=1, timeout counter=0.
REQ-026 Reset mid-frame SHALL abort without another tx_start; the transmitter is not informed.

Configuration
REQ-027 With UART_ARB_TIMEOUT_EN defined, TIMEOUT cycles in WAIT_ACK without tx_busy SHALL pulse tx_err one cycle and return to IDLE; rr_ptr keeps its advanced value.
REQ-028 Without UART_ARB_TIMEOUT_EN, WAIT_ACK SHALL wait indefinitely, tx_err SHALL be tied 0, and no timeout counter SHALL be built.

Structure
REQ-029 Shared package uart_pkg SHALL hold the FSM state encoding constants and default DATA_WIDTH.
REQ-030 A sub-module rr_pick (combinational round-robin search: req, ptr -> one-hot winner, valid) SHALL be used.
REQ-031 The timeout counter width SHALL be $clog2(TIMEOUT+1).

Verification
REQ-032 Single req[2], data 0xA5, tx_busy rises 3 cycles after tx_start and holds 10 cycles -> grant=0b0100 and tx_start in the same cycle, tx_data=0xA5, arb_idle after tx_busy falls.
REQ-033 req=0b1111 held for 8 frames from reset -> grant order 0,1,2,3,0,1,2,3.
REQ-034 req=0b1001 held, rr_ptr=0 -> grants 0,3,0,3.
REQ-035 Macro defined, TIMEOUT=64, tx_busy never asserted -> tx_err pulse 64 cycles after entering WAIT_ACK, then IDLE; macro undefined -> stays WAIT_ACK, tx_err=0.
REQ-036 rst_n low during WAIT_END -> next cycle all outputs at reset values, next arbitration starts at requester 0.
REQ-037 req raised while tx_busy=1 in IDLE -> no grant until tx_busy=0, then grant 2 cycles later.
